// File: rtl/pixel_ctrl_pkg.sv
// Shared types and constants for the pixel array frame sequencer.
//   state_t      : frame phase encoding
//   DEF_*        : default parameter values
//   pix_idx_w()  : width of the pixel index (at least 1 bit)
//   max3()       : used to size the shared phase timer
package pixel_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_READ,
    S_OUT
  } state_t;

  localparam int DEF_N_PIX     = 4;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_ERASE_CYC = 5;
  localparam int DEF_READ_CYC  = 2;

  function automatic int pix_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter used to time the ERASE, EXPOSE and READ phases.
//   clk, reset : clock, synchronous active-high reset
//   i_load     : load i_val this cycle (takes priority over counting)
//   i_val      : phase length in cycles (>=1)
//   o_tc       : high on the last cycle of the loaded phase
// The counter parks at 0 once a phase has run out.
module phase_timer
  import pixel_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)              r_cnt <= '0;
    else if (i_load)        r_cnt <= i_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - W'(1);
  end

  assign o_tc = (r_cnt == W'(1));

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the pixel sensor array: erase, expose, ramp
// conversion, then per-pixel read strobes and a valid/ready code stream.
//   clk, reset        : clock, synchronous active-high reset
//   start, continuous : frame start (IDLE only) / auto-restart at frame end
//   expose_time       : exposure length, latched at frame start, 0 -> 1
//   data_in           : pixel DATA buses, pixel i at [i*CNT_W +: CNT_W]
//   erase/expose/ramp : shared analog controls
//   adc_cnt, cnt_oe   : conversion code counter and its bus enable
//   read              : one-hot pixel read strobes
//   pix_data/idx/valid/ready : captured pixel code stream
//   busy, frame_done  : not-IDLE flag, last-pixel-accepted pulse
module pixel_array_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter  int N_PIX     = DEF_N_PIX,
  parameter  int CNT_W     = DEF_CNT_W,
  parameter  int ERASE_CYC = DEF_ERASE_CYC,
  parameter  int READ_CYC  = DEF_READ_CYC,
  localparam int IW        = pix_idx_w(N_PIX)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   continuous,
  input  logic [CNT_W-1:0]       expose_time,
  input  logic [N_PIX*CNT_W-1:0] data_in,
  output logic                   erase,
  output logic                   expose,
  output logic                   ramp,
  output logic [CNT_W-1:0]       adc_cnt,
  output logic                   cnt_oe,
  output logic [N_PIX-1:0]       read,
  output logic [CNT_W-1:0]       pix_data,
  output logic [IW-1:0]          pix_idx,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int TW = max3(CNT_W, $clog2(ERASE_CYC + 1), $clog2(READ_CYC + 1));

  state_t             r_state, w_state_nxt;
  logic [IW-1:0]      r_k, w_k_nxt;
  logic [CNT_W-1:0]   r_exp, w_exp_in;
  logic [CNT_W-1:0]   r_adc;
  logic               r_erase, r_expose, r_ramp, r_oe, r_valid;
  logic [N_PIX-1:0]   r_read;
  logic [CNT_W-1:0]   r_pix_data;
  logic [IW-1:0]      r_pix_idx;
  logic               w_tmr_load, w_tc, w_last;
  logic [TW-1:0]      w_tmr_val;

  assign w_exp_in = (expose_time == '0) ? CNT_W'(1) : expose_time;

  phase_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .o_tc   (w_tc)
  );

  // Next state, next pixel index and timer loads; the timer is loaded on the
  // transition into each timed phase so o_tc marks that phase's last cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_state_nxt = S_ERASE;
        w_k_nxt     = '0;
        w_tmr_load  = 1'b1;
        w_tmr_val   = TW'(ERASE_CYC);
      end
      S_ERASE: if (w_tc) begin
        w_state_nxt = S_EXPOSE;
        w_tmr_load  = 1'b1;
        w_tmr_val   = TW'(r_exp);
      end
      S_EXPOSE: if (w_tc) w_state_nxt = S_CONVERT;
      S_CONVERT: if (r_adc == '1) begin
        w_state_nxt = S_READ;
        w_tmr_load  = 1'b1;
        w_tmr_val   = TW'(READ_CYC);
      end
      S_READ: if (w_tc) w_state_nxt = S_OUT;
      S_OUT: if (pix_ready) begin
        if (r_k == IW'(N_PIX - 1)) begin
          w_last  = 1'b1;
          w_k_nxt = '0;
          if (continuous) begin
            w_state_nxt = S_ERASE;
            w_tmr_load  = 1'b1;
            w_tmr_val   = TW'(ERASE_CYC);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_k_nxt     = r_k + IW'(1);
          w_state_nxt = S_READ;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TW'(READ_CYC);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is exactly
  // aligned with the phase it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_exp      <= '0;
      r_adc      <= '0;
      r_erase    <= 1'b0;
      r_expose   <= 1'b0;
      r_ramp     <= 1'b0;
      r_oe       <= 1'b0;
      r_read     <= '0;
      r_valid    <= 1'b0;
      r_pix_data <= '0;
      r_pix_idx  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_k      <= w_k_nxt;
      r_erase  <= (w_state_nxt == S_ERASE);
      r_expose <= (w_state_nxt == S_EXPOSE);
      r_ramp   <= (w_state_nxt == S_CONVERT);
      r_oe     <= (w_state_nxt == S_CONVERT);
      r_valid  <= (w_state_nxt == S_OUT);
      r_read   <= (w_state_nxt == S_READ) ? (N_PIX'(1) << w_k_nxt) : '0;
      // counter is 0 on the first CONVERT cycle and cleared on exit
      r_adc    <= (r_state == S_CONVERT && w_state_nxt == S_CONVERT) ? r_adc + CNT_W'(1) : '0;
      if (w_state_nxt == S_ERASE && r_state != S_ERASE) r_exp <= w_exp_in;
      if (r_state == S_READ && w_tc) begin
        r_pix_data <= data_in[int'(r_k)*CNT_W +: CNT_W];
        r_pix_idx  <= r_k;
      end
    end
  end

  assign erase      = r_erase;
  assign expose     = r_expose;
  assign ramp       = r_ramp;
  assign cnt_oe     = r_oe;
  assign adc_cnt    = r_adc;
  assign read       = r_read;
  assign pix_valid  = r_valid;
  assign pix_data   = r_pix_data;
  assign pix_idx    = r_pix_idx;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = w_last;

endmodule

// File: tb/tb_pixel_array_ctrl.sv
module tb_pixel_array_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, continuous, pix_ready;
  logic [7:0]  expose_time;
  logic [31:0] data_in;
  logic        erase, expose, ramp, cnt_oe, pix_valid, busy, frame_done;
  logic [7:0]  adc_cnt, pix_data;
  logic [3:0]  read;
  logic [1:0]  pix_idx;

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  pixel_array_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .expose_time(expose_time), .data_in(data_in), .erase(erase),
    .expose(expose), .ramp(ramp), .adc_cnt(adc_cnt), .cnt_oe(cnt_oe),
    .read(read), .pix_data(pix_data), .pix_idx(pix_idx),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // phase exclusivity and one-hot read, every cycle after the first reset
  always @(negedge clk) begin
    if (mon_en) begin
      n_chk++;
      if ((int'(erase) + int'(expose) + int'(ramp) + int'(|read) + int'(pix_valid)) > 1 ||
          $countones(read) > 1 || (cnt_oe && (|read))) begin
        n_fail++;
        $display("FAIL overlap @%0t: er=%b ex=%b rp=%b oe=%b rd=%b pv=%b, required at most one phase",
                 $time, erase, expose, ramp, cnt_oe, read, pix_valid);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // frame measurements filled by collect()
  int m_cyc, m_er, m_ex, m_rp, m_adc_bad, m_oe_bad, m_done, m_done_bad, m_bp_seen, m_bp_bad;
  int m_rd_len[4];
  int m_rd_first[4];
  int m_acc_cyc[4];
  logic [7:0] m_pd[4];
  bit m_timeout;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs from the first ERASE cycle to one cycle past frame_done, recording
  // what was observed. bp_pix/bp_cyc withhold pix_ready on one pixel;
  // poke drives start whenever expose or a read strobe is high.
  task automatic collect(input int bp_pix, input int bp_cyc, input bit cont, input bit poke);
    int exp_adc, left;
    logic [7:0] hd;
    logic [1:0] hi;
    bit done;
    m_cyc = 0; m_er = 0; m_ex = 0; m_rp = 0; m_adc_bad = 0; m_oe_bad = 0;
    m_done = 0; m_done_bad = 0; m_bp_seen = 0; m_bp_bad = 0; m_timeout = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_rd_len[i] = 0; m_rd_first[i] = -1; m_acc_cyc[i] = -1; m_pd[i] = 8'hxx;
    end
    exp_adc = 0; left = bp_cyc; done = 1'b0; hd = '0; hi = '0;
    for (int c = 0; c < 2000 && !done; c++) begin
      pix_ready  = !(pix_valid && int'(pix_idx) == bp_pix && left > 0);
      continuous = cont;
      start      = poke && (expose || (read != 4'b0));
      #1;
      m_cyc++;
      if (erase)  m_er++;
      if (expose) m_ex++;
      if (ramp) begin
        m_rp++;
        if (adc_cnt !== 8'(exp_adc)) m_adc_bad++;
        exp_adc++;
      end else if (adc_cnt !== 8'd0) m_adc_bad++;
      if (cnt_oe !== ramp) m_oe_bad++;
      for (int i = 0; i < 4; i++) begin
        if (read == (4'b0001 << i)) begin
          if (m_rd_len[i] == 0) m_rd_first[i] = c;
          m_rd_len[i]++;
        end
      end
      if (pix_valid && !pix_ready) begin
        if (m_bp_seen == 0) begin hd = pix_data; hi = pix_idx; end
        else if (pix_data !== hd || pix_idx !== hi || read !== 4'b0) m_bp_bad++;
        m_bp_seen++;
        left--;
      end
      if (pix_valid && pix_ready) begin
        m_pd[int'(pix_idx)] = pix_data;
        m_acc_cyc[int'(pix_idx)] = c;
      end
      if (frame_done) begin
        m_done++;
        if (!(pix_valid && pix_ready && pix_idx == 2'd3)) m_done_bad++;
        done = 1'b1;
      end
      step();
    end
    if (!done) m_timeout = 1'b1;
    start = 1'b0;
    pix_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; continuous = 1'b0; pix_ready = 1'b1;
    expose_time = 8'd0; data_in = 32'h0;
    step(); step();
    n_chk++; if ({erase, expose, ramp, cnt_oe, pix_valid, busy, frame_done} !== 7'b0) begin
      n_fail++; $display("FAIL rst_ctrl: got %b want 0000000", {erase, expose, ramp, cnt_oe, pix_valid, busy, frame_done}); end
    n_chk++; if (adc_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_adc: got %h want 00", adc_cnt); end
    n_chk++; if (read !== 4'b0) begin n_fail++; $display("FAIL rst_read: got %b want 0000", read); end
    n_chk++; if ({pix_data, pix_idx} !== 10'd0) begin n_fail++; $display("FAIL rst_pix: got %h/%0d want 00/0", pix_data, pix_idx); end
    reset = 1'b0;
    mon_en = 1'b1;
    step(); step();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_frame();
    expose_time = 8'd10; data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    start_frame();
    collect(-1, 0, 1'b0, 1'b0);
    n_chk++; if (m_timeout) begin n_fail++; $display("FAIL f1_timeout: frame_done never seen"); end
    n_chk++; if (m_er !== 5) begin n_fail++; $display("FAIL f1_erase: got %0d want 5", m_er); end
    n_chk++; if (m_ex !== 10) begin n_fail++; $display("FAIL f1_expose: got %0d want 10", m_ex); end
    n_chk++; if (m_rp !== 256) begin n_fail++; $display("FAIL f1_ramp: got %0d want 256", m_rp); end
    n_chk++; if (m_adc_bad !== 0 || m_oe_bad !== 0) begin n_fail++; $display("FAIL f1_adc: bad %0d/%0d want 0/0", m_adc_bad, m_oe_bad); end
    n_chk++; if (m_cyc !== 283) begin n_fail++; $display("FAIL f1_len: got %0d want 283", m_cyc); end
    n_chk++; if (m_done !== 1 || m_done_bad !== 0) begin n_fail++; $display("FAIL f1_done: got %0d/%0d want 1/0", m_done, m_done_bad); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (m_rd_len[i] !== 2 || m_rd_first[i] !== 271 + 3*i) begin n_fail++;
        $display("FAIL f1_read%0d: len %0d at %0d want 2 at %0d", i, m_rd_len[i], m_rd_first[i], 271 + 3*i); end
      n_chk++; if (m_pd[i] !== 8'(8'h11 * (i + 1)) || m_acc_cyc[i] !== 273 + 3*i) begin n_fail++;
        $display("FAIL f1_pix%0d: %h at %0d want %h at %0d", i, m_pd[i], m_acc_cyc[i], 8'(8'h11 * (i + 1)), 273 + 3*i); end
    end
    step(); step();
    n_chk++; if (busy !== 1'b0 || erase !== 1'b0) begin n_fail++; $display("FAIL f1_idle: busy %b erase %b want 0 0", busy, erase); end
  endtask

  task automatic test_expose_zero();
    expose_time = 8'd0;
    start_frame();
    collect(-1, 0, 1'b0, 1'b0);
    n_chk++; if (m_ex !== 1) begin n_fail++; $display("FAIL ez_expose: got %0d want 1", m_ex); end
    n_chk++; if (m_cyc !== 274) begin n_fail++; $display("FAIL ez_len: got %0d want 274", m_cyc); end
  endtask

  task automatic test_backpressure();
    expose_time = 8'd10; data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    start_frame();
    collect(1, 7, 1'b0, 1'b0);
    n_chk++; if (m_bp_seen !== 7 || m_bp_bad !== 0) begin n_fail++; $display("FAIL bp_hold: seen %0d bad %0d want 7 0", m_bp_seen, m_bp_bad); end
    n_chk++; if (m_pd[1] !== 8'h22 || m_acc_cyc[1] !== 283) begin n_fail++; $display("FAIL bp_pix1: %h at %0d want 22 at 283", m_pd[1], m_acc_cyc[1]); end
    n_chk++; if (m_rd_first[2] !== 284) begin n_fail++; $display("FAIL bp_read2: at %0d want 284", m_rd_first[2]); end
    n_chk++; if (m_cyc !== 290) begin n_fail++; $display("FAIL bp_len: got %0d want 290", m_cyc); end
  endtask

  task automatic test_back_to_back();
    expose_time = 8'd3;
    start_frame();
    expose_time = 8'd6;  // relatched only at the continuous restart
    collect(-1, 0, 1'b1, 1'b0);
    n_chk++; if (m_ex !== 3 || m_cyc !== 276) begin n_fail++; $display("FAIL b2b_f1: ex %0d len %0d want 3 276", m_ex, m_cyc); end
    n_chk++; if (erase !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: erase %b busy %b want 1 1", erase, busy); end
    collect(-1, 0, 1'b0, 1'b0);
    n_chk++; if (m_ex !== 6 || m_cyc !== 279 || m_er !== 5) begin n_fail++; $display("FAIL b2b_f2: ex %0d len %0d er %0d want 6 279 5", m_ex, m_cyc, m_er); end
    step();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy %b want 0", busy); end
  endtask

  task automatic test_mid_reset();
    bit hit;
    expose_time = 8'd10; data_in = {8'hd4, 8'hc3, 8'hb2, 8'ha1};
    start_frame();
    hit = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      if (ramp && adc_cnt == 8'd99) hit = 1'b1;
      else step();
    end
    n_chk++; if (!hit) begin n_fail++; $display("FAIL mr_reach: CONVERT cycle 100 not reached"); end
    reset = 1'b1;
    step();
    n_chk++; if ({erase, expose, ramp, cnt_oe, pix_valid, busy, frame_done, read, adc_cnt} !== 19'd0) begin n_fail++;
      $display("FAIL mr_zero: ctrl %b read %b adc %h want all 0", {erase, expose, ramp, cnt_oe, pix_valid, busy, frame_done}, read, adc_cnt); end
    reset = 1'b0;
    step(); step();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mr_idle: busy %b want 0", busy); end
    start_frame();
    collect(-1, 0, 1'b0, 1'b0);
    n_chk++; if (m_cyc !== 283 || m_ex !== 10 || m_rp !== 256 || m_adc_bad !== 0) begin n_fail++;
      $display("FAIL mr_frame: len %0d ex %0d rp %0d adcbad %0d want 283 10 256 0", m_cyc, m_ex, m_rp, m_adc_bad); end
    n_chk++; if ({m_pd[3], m_pd[2], m_pd[1], m_pd[0]} !== 32'hd4c3b2a1) begin n_fail++;
      $display("FAIL mr_pix: got %h want d4c3b2a1", {m_pd[3], m_pd[2], m_pd[1], m_pd[0]}); end
  endtask

  task automatic test_start_ignored();
    expose_time = 8'd10; data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    start_frame();
    collect(-1, 0, 1'b0, 1'b1);
    n_chk++; if (m_ex !== 10 || m_er !== 5 || m_cyc !== 283) begin n_fail++;
      $display("FAIL si_len: ex %0d er %0d len %0d want 10 5 283", m_ex, m_er, m_cyc); end
    n_chk++; if (m_rd_len[0] !== 2 || m_rd_len[1] !== 2 || m_rd_len[2] !== 2 || m_rd_len[3] !== 2) begin n_fail++;
      $display("FAIL si_read: %0d %0d %0d %0d want 2 2 2 2", m_rd_len[0], m_rd_len[1], m_rd_len[2], m_rd_len[3]); end
    step();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL si_idle: busy %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_expose_zero();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_start_ignored();
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
